// File: rtl/memory_cycle_hs.sv
// memory_cycle_hs
//
// Memory pipeline stage that sits right after execute. Loads and stores go out
// over a req/ready data-memory bus that may insert wait states. While an access
// is outstanding, StallM freezes the upstream stages. Every retired instruction
// is registered into the W-stage outputs, and ResultW is fed back for forwarding.
//
// Optional feature: define DMEM_TIMEOUT_EN to enable an access timeout.
//   - An access that stays in BUSY for TIMEOUT_CYCLES cycles without ready is
//     abandoned.
//   - The instruction then retires with ReadDataW = 0, and dmem_err pulses for
//     one cycle.
//   - Without the macro, BUSY waits indefinitely and dmem_err is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  wait-state limit per access, 1..255 (timeout build only)
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   RegWriteM .. ALU_ResultM  registered M-stage controls and data
//   dmem_req/we/addr/wdata    data-memory request side
//   dmem_rdata/ready          data-memory response side
//   StallM                    freeze IF/ID/EX and hold the M inputs
//   dmem_err                  one-cycle pulse on an access timeout
//   *W, ResultW               W-stage registers and write-back mux

module memory_cycle_hs #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        StallM,
    output logic        dmem_err,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ResultW
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("memory_cycle_hs: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, next_state;

    logic        acc;
    logic        stall;
    logic        capture_m;
    logic        capture_lat;
    logic        bubble;
    logic        timeout_hit;

    logic        lat_we;
    logic        lat_regwrite;
    logic        lat_resultsrc;
    logic [4:0]  lat_rd;
    logic [31:0] lat_pcplus4;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    assign acc = MemWriteM | ResultSrcM;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // The counter is cleared during the IDLE cycle that launches the access.
    // The compare value is TIMEOUT_CYCLES-1, so the abort takes effect in the
    // TIMEOUT_CYCLES-th BUSY cycle that passes without ready.
    assign timeout_hit = (state == BUSY) && !dmem_ready &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            dmem_err <= 1'b0;
        end else begin
            dmem_err <= timeout_hit;
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (!dmem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign dmem_err    = 1'b0;
`endif

    // Next-state and handshake decode.
    // A timeout is treated like a completion, so StallM drops in that same
    // cycle. This lets the pipeline advance past the abandoned instruction
    // instead of re-issuing it.
    always_comb begin
        next_state  = state;
        stall       = 1'b0;
        capture_m   = 1'b0;
        capture_lat = 1'b0;
        bubble      = 1'b0;
        unique case (state)
            IDLE: begin
                if (acc && !dmem_ready) begin
                    next_state = BUSY;
                    stall      = 1'b1;
                    bubble     = 1'b1;
                end else begin
                    capture_m  = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ready || timeout_hit) begin
                    next_state  = IDLE;
                    capture_lat = 1'b1;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs. In IDLE they follow the M inputs directly; in BUSY they come
    // from the latched copy. Request and stall are gated by rst, so an access
    // in flight disappears as soon as reset is asserted.
    always_comb begin
        if (state == BUSY) begin
            dmem_req   = !rst;
            dmem_we    = lat_we;
            dmem_addr  = lat_addr;
            dmem_wdata = lat_wdata;
        end else begin
            dmem_req   = acc && !rst;
            dmem_we    = MemWriteM;
            dmem_addr  = ALU_ResultM;
            dmem_wdata = WriteDataM;
        end
        StallM = stall && !rst;
    end

    // State register, request latch and W-stage registers.
    // A bubble clears only the write and load-select bits; the remaining W
    // fields simply hold their previous values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_regwrite  <= 1'b0;
            lat_resultsrc <= 1'b0;
            lat_rd        <= '0;
            lat_pcplus4   <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            RegWriteW     <= 1'b0;
            ResultSrcW    <= 1'b0;
            RD_W          <= '0;
            PCPlus4W      <= '0;
            ALU_ResultW   <= '0;
            ReadDataW     <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && acc && !dmem_ready) begin
                lat_we        <= MemWriteM;
                lat_regwrite  <= RegWriteM;
                lat_resultsrc <= ResultSrcM;
                lat_rd        <= RD_M;
                lat_pcplus4   <= PCPlus4M;
                lat_addr      <= ALU_ResultM;
                lat_wdata     <= WriteDataM;
            end
            if (capture_m) begin
                RegWriteW   <= RegWriteM;
                ResultSrcW  <= ResultSrcM;
                RD_W        <= RD_M;
                PCPlus4W    <= PCPlus4M;
                ALU_ResultW <= ALU_ResultM;
                ReadDataW   <= ResultSrcM ? dmem_rdata : 32'd0;
            end else if (capture_lat) begin
                RegWriteW   <= lat_regwrite;
                ResultSrcW  <= lat_resultsrc;
                RD_W        <= lat_rd;
                PCPlus4W    <= lat_pcplus4;
                ALU_ResultW <= lat_addr;
                ReadDataW   <= (lat_resultsrc && !timeout_hit) ? dmem_rdata : 32'd0;
            end else if (bubble) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= 1'b0;
            end
        end
    end

    assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule

// File: tb/tb_memory_cycle_hs.sv
// tb_memory_cycle_hs
//
// Scoreboard bench for memory_cycle_hs.
//   - When an instruction is driven into M, its expected W-stage values are
//     pushed onto a queue.
//   - A monitor treats an instruction as retired at every edge where it was
//     present in M without StallM. It then pops the queue and compares.
//   - Per-cycle bus and stall behaviour is checked inline by the stimulus task.
//
// With DMEM_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYCLES = 4 and a
// timeout scenario is added.

module tb_memory_cycle_hs;

`ifdef DMEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        StallM, dmem_err;
    logic        RegWriteW, ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

    memory_cycle_hs #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .StallM(StallM), .dmem_err(dmem_err),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .ResultW(ResultW)
    );

    typedef struct {
        logic        regwrite;
        logic        resultsrc;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] result;
    } wexp_t;

    wexp_t sb[$];
    wexp_t mon_e;
    int    nVectors = 0;
    int    nMiscompares = 0;
    logic  mValid = 1'b0;
    logic  retireS = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic idleM();
        RegWriteM   = 1'b0;
        MemWriteM   = 1'b0;
        ResultSrcM  = 1'b0;
        RD_M        = '0;
        PCPlus4M    = '0;
        WriteDataM  = '0;
        ALU_ResultM = '0;
        dmem_ready  = 1'b0;
        dmem_rdata  = '0;
        mValid      = 1'b0;
    endtask

    // Sampled on the negedge, while the M inputs are stable and away from the
    // active clock edge.
    always @(negedge clk) retireS = mValid && !StallM && !rst;

    always @(posedge clk) begin
        if (retireS) begin
            #1;
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("RegWriteW",   32'(RegWriteW),  32'(mon_e.regwrite));
                checkOutput("ResultSrcW",  32'(ResultSrcW), 32'(mon_e.resultsrc));
                checkOutput("RD_W",        32'(RD_W),       32'(mon_e.rd));
                checkOutput("PCPlus4W",    PCPlus4W,        mon_e.pc);
                checkOutput("ALU_ResultW", ALU_ResultW,     mon_e.alu);
                checkOutput("ReadDataW",   ReadDataW,       mon_e.rdata);
                checkOutput("ResultW",     ResultW,         mon_e.result);
            end
        end
    end

    // Drives one instruction starting just after a posedge. The slave answers
    // after 'waits' wait states. Returns one time unit after the retiring edge.
    task automatic applyStimulus(input logic rw, input logic mw, input logic rs,
                                 input logic [4:0] rd, input logic [31:0] pc,
                                 input logic [31:0] wd, input logic [31:0] alu,
                                 input int waits, input logic [31:0] rdata);
        wexp_t e;
        logic  acc;
        int    last;
        acc = mw | rs;
        last = acc ? waits : 0;
        RegWriteM = rw;  MemWriteM = mw;   ResultSrcM = rs;
        RD_M = rd;       PCPlus4M = pc;    WriteDataM = wd;
        ALU_ResultM = alu;
        mValid = 1'b1;
        e.regwrite  = rw;
        e.resultsrc = rs;
        e.rd        = rd;
        e.pc        = pc;
        e.alu       = alu;
        e.rdata     = rs ? rdata : 32'd0;
        e.result    = rs ? rdata : alu;
        sb.push_back(e);
        for (int i = 0; i <= last; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                checkOutput("bubble_RegWriteW", 32'(RegWriteW), 32'd0);
            end
            dmem_ready = acc && (i == waits);
            dmem_rdata = dmem_ready ? rdata : $urandom();
            #3;
            checkOutput("StallM", 32'(StallM), 32'(acc && (i < waits)));
            checkOutput("dmem_req", 32'(dmem_req), 32'(acc));
            if (acc) begin
                checkOutput("dmem_addr", dmem_addr, alu);
                checkOutput("dmem_we", 32'(dmem_we), 32'(mw));
                if (mw) checkOutput("dmem_wdata", dmem_wdata, wd);
            end
        end
        @(posedge clk);
        #1;
        idleM();
    endtask

    initial begin
        rst = 1'b0;
        idleM();
        #1;
        rst = 1'b1;
        #2;
        $display("[TB] reset state");
        checkOutput("rst_StallM", 32'(StallM), 32'd0);
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("rst_ResultW", ResultW, 32'd0);
        checkOutput("rst_err", 32'(dmem_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] ALU op");
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1004, 32'h0, 32'h0000_1234, 0, 32'h0);
        $display("[TB] zero-wait load");
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_1008, 32'h0, 32'h0000_0100, 0, 32'hCAFE_F00D);
        $display("[TB] store with three wait states");
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_100C, 32'hA5A5_A5A5, 32'h0000_0200, 3, 32'h0);
        $display("[TB] load with wait states, then back-to-back store");
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_1010, 32'h0, 32'h0000_0180, 2, 32'h1357_9BDF);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_1014, 32'h0BAD_BEEF, 32'h0000_0204, 0, 32'h0);
        $display("[TB] randomized ALU ops and loads");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, k[0], 5'($urandom_range(1, 31)), $urandom(),
                          32'h0, $urandom(), $urandom_range(0, 3), $urandom());
        end
        checkOutput("dmem_err_idle", 32'(dmem_err), 32'd0);

`ifdef DMEM_TIMEOUT_EN
        $display("[TB] timeout");
        begin
            wexp_t e;
            RegWriteM = 1'b1; ResultSrcM = 1'b1; MemWriteM = 1'b0;
            RD_M = 5'd7; PCPlus4M = 32'h0000_2004; ALU_ResultM = 32'h0000_0300;
            mValid = 1'b1;
            e.regwrite = 1'b1; e.resultsrc = 1'b1; e.rd = 5'd7;
            e.pc = 32'h0000_2004; e.alu = 32'h0000_0300;
            e.rdata = 32'd0; e.result = 32'd0;
            sb.push_back(e);
            for (int i = 0; i <= TB_TIMEOUT; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                dmem_ready = 1'b0;
                #3;
                checkOutput("to_StallM", 32'(StallM), 32'(i < TB_TIMEOUT));
                checkOutput("to_err_low", 32'(dmem_err), 32'd0);
            end
            @(posedge clk);
            #1;
            idleM();
            checkOutput("to_err_pulse", 32'(dmem_err), 32'd1);
            checkOutput("to_StallM_after", 32'(StallM), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("to_err_cleared", 32'(dmem_err), 32'd0);
        end
`endif

        $display("[TB] reset during BUSY");
        RegWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd3;
        PCPlus4M = 32'h0000_3004; ALU_ResultM = 32'h0000_0040;
        dmem_ready = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("busy_req", 32'(dmem_req), 32'd1);
        checkOutput("busy_StallM", 32'(StallM), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_req", 32'(dmem_req), 32'd0);
        checkOutput("arst_StallM", 32'(StallM), 32'd0);
        checkOutput("arst_RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("arst_RD_W", 32'(RD_W), 32'd0);
        checkOutput("arst_PCPlus4W", PCPlus4W, 32'd0);
        checkOutput("arst_ALU_ResultW", ALU_ResultW, 32'd0);
        checkOutput("arst_ReadDataW", ReadDataW, 32'd0);
        checkOutput("arst_ResultW", ResultW, 32'd0);
        idleM();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_RegWriteW", 32'(RegWriteW), 32'd0);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
